// File: rtl/jump_ctrl_pkg.sv
// Shared types and helpers for the jump control unit.
//   state_t      : sequencer states (IDLE, WAIT)
//   jump_kind_t  : decoded jump in ID after priority resolution
//   encode_jump  : priority encoder JumpI > JumpCI > JumpCD
//   multi_jump   : true when two or more jump inputs are high together
package jump_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    J_NONE   = 2'd0,
    J_UNCOND = 2'd1,
    J_EQ     = 2'd2,
    J_NE     = 2'd3
  } jump_kind_t;

  function automatic jump_kind_t encode_jump(input logic ji, input logic jci, input logic jcd);
    jump_kind_t kind;
    if (ji) begin
      kind = J_UNCOND;
    end else if (jci) begin
      kind = J_EQ;
    end else if (jcd) begin
      kind = J_NE;
    end else begin
      kind = J_NONE;
    end
    return kind;
  endfunction

  function automatic logic multi_jump(input logic ji, input logic jci, input logic jcd);
    return (ji & jci) | (ji & jcd) | (jci & jcd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock and asynchronous active-low reset (clears to 0)
//   inc        : increment by one this cycle (ignored once all-ones)
//   count      : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // Count register; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != ALL_ONES)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/jump_control_unit.sv
// Control-flow sequencer for the ID stage.
// Resolves jumps in ID, holding conditional jumps while the Z flag is still
// being produced in EX/MEM, and drives PC-select plus stall/flush controls.
//   clk, rst_n                : clock, asynchronous active-low reset
//   JumpI_D/JumpCI_D/JumpCD_D : jump flags of the instruction in ID
//   FlagWriteE/FlagWriteM     : a flag write is still in flight
//   FlagZ                     : committed Z flag
//   MemStall                  : global freeze from the memory system
//   PCSource                  : select the jump target as next PC
//   StallF/StallD             : hold PC / IF-ID register
//   FlushD/FlushE             : clear IF-ID / bubble into ID-EX
//   JumpCount/TakenCount      : saturating jump statistics
//   MultiErr/TimeoutErr       : sticky error flags
module jump_control_unit
  import jump_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             JumpI_D,
  input  logic             JumpCI_D,
  input  logic             JumpCD_D,
  input  logic             FlagWriteE,
  input  logic             FlagWriteM,
  input  logic             FlagZ,
  input  logic             MemStall,
  output logic             PCSource,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] JumpCount,
  output logic [CNT_W-1:0] TakenCount,
  output logic             MultiErr,
  output logic             TimeoutErr
);

  // One extra count value lets the counter park just past MAX_WAIT.
  localparam int WCNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WAIT_SAT   = WCNT_W'(MAX_WAIT + 1);

  state_t            state_r;
  state_t            state_next_s;
  jump_kind_t        kind_s;
  logic              busy_s;
  logic              hold_s;
  logic              resolve_s;
  logic              taken_s;
  logic              inc_jump_s;
  logic              inc_taken_s;
  logic [WCNT_W-1:0] wait_cnt_r;

  // Decode the jump in ID and decide hold / resolve / direction.
  always_comb begin
    kind_s    = encode_jump(JumpI_D, JumpCI_D, JumpCD_D);
    busy_s    = FlagWriteE | FlagWriteM;
    hold_s    = ((kind_s == J_EQ) || (kind_s == J_NE)) && busy_s;
    resolve_s = (kind_s != J_NONE) && !hold_s;
    case (kind_s)
      J_UNCOND: taken_s = 1'b1;
      J_EQ:     taken_s = FlagZ;
      J_NE:     taken_s = !FlagZ;
      default:  taken_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: WAIT exactly while a conditional jump is held on a busy flag.
  // If the jump vanishes from ID during WAIT we fall back to IDLE unresolved.
  always_comb begin
    state_next_s = state_r;
    if (MemStall) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        IDLE:    state_next_s = hold_s ? WAIT : IDLE;
        WAIT:    state_next_s = hold_s ? WAIT : IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Control outputs; reset forces them low so a mid-wait reset is silent.
  always_comb begin
    PCSource = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    if (!rst_n) begin
      PCSource = 1'b0;
    end else if (MemStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (hold_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (resolve_s) begin
      PCSource = taken_s;
      FlushD   = taken_s;
    end else begin
      PCSource = 1'b0;
    end
  end

  // Wait counter: number of stall cycles spent on the current flag wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end else if (MemStall) begin
      wait_cnt_r <= wait_cnt_r;
    end else if (hold_s && (state_r == IDLE)) begin
      wait_cnt_r <= WCNT_W'(1);
    end else if (hold_s && (wait_cnt_r != WAIT_SAT)) begin
      wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
    end else if (hold_s) begin
      wait_cnt_r <= wait_cnt_r;
    end else begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end
  end

  // Sticky error flags; the timeout only reports, it never forces resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MultiErr   <= 1'b0;
      TimeoutErr <= 1'b0;
    end else if (MemStall) begin
      MultiErr   <= MultiErr;
      TimeoutErr <= TimeoutErr;
    end else begin
      MultiErr   <= MultiErr | multi_jump(JumpI_D, JumpCI_D, JumpCD_D);
      TimeoutErr <= TimeoutErr |
                    (hold_s && (state_r == WAIT) && (wait_cnt_r >= WAIT_LIMIT));
    end
  end

  assign inc_jump_s  = resolve_s && !MemStall;
  assign inc_taken_s = inc_jump_s && taken_s;

  sat_counter #(.W(CNT_W)) u_jump_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_jump_s),
    .count (JumpCount)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken_s),
    .count (TakenCount)
  );

endmodule
